// File: rtl/ultrasonido_scheduler.sv
// Round-robin ranging scheduler for N HC-SR04 style sensors: one ping in flight at a time,
// trigger -> echo wait -> echo width measurement -> publish -> guard interval.
module ultrasonido_scheduler #(
    parameter int N_SENS       = 4,
    parameter int CNT_W        = 22,
    parameter int TRIG_CYCLES  = 500,
    parameter int TIMEOUT      = 900000,
    parameter int GUARD_CYCLES = 100000,
    parameter int THRESH       = 346000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scan_en,
    input  logic              start,
    input  logic [N_SENS-1:0] sens_mask,
    input  logic [N_SENS-1:0] echo,
    output logic [N_SENS-1:0] trigger,
    output logic              busy,
    output logic              meas_valid,
    output logic [2:0]        meas_id,
    output logic [CNT_W-1:0]  meas_count,
    output logic              meas_timeout,
    output logic [N_SENS-1:0] near
);

    typedef enum logic [2:0] {
        IDLE, SELECT, TRIG, WAIT_ECHO, MEASURE, PUBLISH, GUARD
    } state_t;

    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST   = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] THRESH_CNT   = CNT_W'(THRESH);
    localparam logic [2:0]       LAST_SENS    = 3'(N_SENS - 1);

    state_t            state, next_state;
    logic [N_SENS-1:0] echo_meta, echo_sync;
    logic [CNT_W-1:0]  counter;
    logic [2:0]        cur_id, last_id, sel_id, trig_id;
    logic              sel_found, echo_cur;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign busy       = (state != IDLE);
    assign meas_valid = (state == PUBLISH);
    assign trig_id    = (state == SELECT) ? sel_id : cur_id;

    always_comb begin
        echo_cur = 1'b0;
        for (int i = 0; i < N_SENS; i++)
            if (cur_id == 3'(i)) echo_cur = echo_sync[i];
    end

    // Circular search starting just after the last served sensor; last_id+k never exceeds 2*N_SENS-1.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        for (int k = 1; k <= N_SENS; k++) begin
            for (int i = 0; i < N_SENS; i++) begin
                if (!sel_found && sens_mask[i] &&
                    ((int'(last_id) + k == i) || (int'(last_id) + k == i + N_SENS))) begin
                    sel_found = 1'b1;
                    sel_id    = 3'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (scan_en || start) next_state = SELECT;
            SELECT:    next_state = sel_found ? TRIG : IDLE;
            TRIG:      if (counter == TRIG_LAST) next_state = WAIT_ECHO;
            WAIT_ECHO: begin
                if (echo_cur)                     next_state = MEASURE;
                else if (counter == TIMEOUT_LAST) next_state = PUBLISH;
            end
            MEASURE:   if (!echo_cur || counter == TIMEOUT_LAST) next_state = PUBLISH;
            PUBLISH:   next_state = GUARD;
            GUARD:     if (counter == GUARD_LAST) next_state = scan_en ? SELECT : IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // The rise-detect cycle spent in WAIT_ECHO belongs to the pulse, hence the +1 on the falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            echo_meta    <= '0;
            echo_sync    <= '0;
            trigger      <= '0;
            counter      <= '0;
            cur_id       <= '0;
            last_id      <= LAST_SENS;
            meas_id      <= '0;
            meas_count   <= '0;
            meas_timeout <= 1'b0;
            near         <= '0;
        end else begin
            echo_meta <= echo;
            echo_sync <= echo_meta;
            for (int i = 0; i < N_SENS; i++)
                trigger[i] <= (next_state == TRIG) && (trig_id == 3'(i));
            case (state)
                SELECT: begin
                    counter <= '0;
                    if (sel_found) begin
                        cur_id  <= sel_id;
                        last_id <= sel_id;
                    end
                end
                TRIG: counter <= (counter == TRIG_LAST) ? '0 : sat_inc(counter);
                WAIT_ECHO: begin
                    if (echo_cur) begin
                        counter <= '0;
                    end else if (counter == TIMEOUT_LAST) begin
                        meas_id      <= cur_id;
                        meas_count   <= '0;
                        meas_timeout <= 1'b1;
                    end else begin
                        counter <= sat_inc(counter);
                    end
                end
                MEASURE: begin
                    if (!echo_cur) begin
                        meas_id      <= cur_id;
                        meas_count   <= sat_inc(counter);
                        meas_timeout <= 1'b0;
                    end else if (counter == TIMEOUT_LAST) begin
                        meas_id      <= cur_id;
                        meas_count   <= '0;
                        meas_timeout <= 1'b1;
                    end else begin
                        counter <= sat_inc(counter);
                    end
                end
                PUBLISH: begin
                    counter <= '0;
                    for (int i = 0; i < N_SENS; i++)
                        if (cur_id == 3'(i)) near[i] <= !meas_timeout && (meas_count < THRESH_CNT);
                end
                GUARD: if (counter != GUARD_LAST) counter <= sat_inc(counter);
                default: ;
            endcase
        end
    end

endmodule
